// File: rtl/ct_stream_out_pkg.sv
// ct_stream_out_pkg: shared ciphertext types, sizes and the stream FSM state enum
package ct_stream_out_pkg;
  localparam int N_SLOTS_L = 4;
  localparam int W_BITS_L  = 8;
  localparam int Q_MOD_L   = 97;
  typedef logic [W_BITS_L-1:0] word_t;
  typedef word_t [N_SLOTS_L-1:0] poly_t;
  typedef poly_t PT_t;
  typedef struct packed {
    poly_t a;
    poly_t b;
  } CT_t;
  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} stream_state_e;
endpackage

// File: rtl/ct_coeff_mux.sv
// ct_coeff_mux: picks one coefficient word out of a ciphertext by polynomial select and index
module ct_coeff_mux
  import ct_stream_out_pkg::*;
#(
  parameter int IW = 2
) (
  input  CT_t           ct_i,
  input  logic          sel_i,
  input  logic [IW-1:0] idx_i,
  output word_t         data_o
);
  assign data_o = sel_i ? ct_i.b[idx_i] : ct_i.a[idx_i];
endmodule

// File: rtl/ct_stream_out.sv
// ct_stream_out: captures a ciphertext and streams A[0..N-1] then B[0..N-1]; range check under CT_STREAM_RANGE_CHECK_EN
module ct_stream_out
  import ct_stream_out_pkg::*;
#(
  parameter int          N  = N_SLOTS_L,
  parameter int          W  = W_BITS_L,
  parameter int unsigned QP = Q_MOD_L,
  parameter int          IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  CT_t           in_ct,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_sel,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          out_range_err
);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  stream_state_e state_q, state_d;
  CT_t           buf_q, buf_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          last_q, last_d;
  logic          hs, cap;
  word_t         mux_word;
  assign out_valid = state_q != IDLE;
  assign busy      = state_q != IDLE;
  assign out_sel   = state_q == SEND_B;
  assign out_idx   = cnt_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign hs        = out_valid & out_ready;
  assign in_ready  = (state_q == IDLE) | (hs & last_q);
  assign cap       = in_valid & in_ready;
  // The mux looks at the next-cycle buffer and position so the beat word is registered with them
  ct_coeff_mux #(.IW(IW)) u_mux (
    .ct_i   (buf_d),
    .sel_i  (state_d == SEND_B),
    .idx_i  (cnt_d),
    .data_o (mux_word)
  );
  // Next beat position: capture restarts at A[0], a handshake advances, otherwise hold
  always_comb begin
    buf_d   = cap ? in_ct : buf_q;
    state_d = cap ? SEND_A :
              !hs ? state_q :
              last_q ? IDLE :
              (state_q == SEND_A && cnt_q == LAST_IDX) ? SEND_B : state_q;
    cnt_d   = cap ? '0 : !hs ? cnt_q : (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    last_d  = (state_d == SEND_B) && (cnt_d == LAST_IDX);
    data_d  = (state_d == IDLE) ? '0 : mux_word;
  end
  // FSM state, captured ciphertext and registered beat outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end
`ifdef CT_STREAM_RANGE_CHECK_EN
  localparam int unsigned QW = W + 32;
  logic err_q, beat_err;
  assign beat_err      = out_valid && (QW'(out_data) >= QW'(QP));
  assign out_range_err = beat_err | (out_valid & last_q & err_q);
  // Sticky flag: any out-of-range beat of the current ciphertext, cleared on the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (cap) err_q <= 1'b0;
    else if (hs && beat_err) err_q <= 1'b1;
  end
`else
  assign out_range_err = 1'b0;
`endif
endmodule

// File: tb/tb_ct_stream_out.sv
// tb_ct_stream_out: directed checks of ct_stream_out with N=4, W=8, Q=97
module tb_ct_stream_out;
  import ct_stream_out_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready, out_sel, out_last, busy, out_range_err;
  CT_t        in_ct, cur, c1, c2, c3;
  logic [7:0] out_data;
  logic [1:0] out_idx;
  int         n_cmp = 0;
  int         n_err = 0;
  always #5 clk = ~clk;
  ct_stream_out dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ct(in_ct),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .out_range_err(out_range_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input CT_t ct);
    in_ct = ct;
    in_valid = 1'b1;
    #1;
    chk("cap_in_ready", 32'(in_ready), 1);
    chk("cap_out_valid_before", 32'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  function automatic logic [7:0] exp_word(input CT_t ct, input int beat);
    return beat < 4 ? ct.a[beat] : ct.b[beat-4];
  endfunction
  task automatic drain(input int stall_at, input int stall_len, input bit b2b);
    int beat = 0;
    int st = 0;
    int cyc = 0;
    bit err_seen = 1'b0;
    logic [7:0] w;
    bit exp_err;
    while (beat < 8 && cyc < 100) begin
      out_ready = !(beat == stall_at && st < stall_len);
      if (!out_ready) st++;
      in_valid = b2b && beat == 7;
      if (b2b) in_ct = c2;
      #1;
      w = exp_word(cur, beat);
`ifdef CT_STREAM_RANGE_CHECK_EN
      exp_err = (w >= 8'd97) || (beat == 7 && err_seen);
`else
      exp_err = 1'b0;
`endif
      chk("beat_valid", 32'(out_valid), 1);
      chk("beat_busy", 32'(busy), 1);
      chk("beat_data", 32'(out_data), 32'(w));
      chk("beat_sel", 32'(out_sel), 32'(beat >= 4));
      chk("beat_idx", 32'(out_idx), 32'(beat % 4));
      chk("beat_last", 32'(out_last), 32'(beat == 7));
      chk("beat_in_ready", 32'(in_ready), 32'(out_ready && beat == 7));
      chk("beat_range_err", 32'(out_range_err), 32'(exp_err));
      @(posedge clk); #1;
      if (out_ready) begin
        if (w >= 8'd97) err_seen = 1'b1;
        beat++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("beat_count", 32'(beat), 8);
  endtask
  initial begin
    c1 = '{a: '{8'd4, 8'd3, 8'd2, 8'd1}, b: '{8'd8, 8'd7, 8'd6, 8'd5}};
    c2 = '{a: '{8'd13, 8'd12, 8'd11, 8'd10}, b: '{8'd23, 8'd22, 8'd21, 8'd20}};
    c3 = '{a: '{8'd50, 8'd40, 8'd30, 8'd20}, b: '{8'd200, 8'd9, 8'd97, 8'd96}};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ct = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_range_err", 32'(out_range_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_out_valid", 32'(out_valid), 0);
    cur = c1;
    send(c1);
    drain(-1, 0, 1'b0);
    chk("post_basic_valid", 32'(out_valid), 0);
    chk("post_basic_busy", 32'(busy), 0);
    chk("post_basic_in_ready", 32'(in_ready), 1);
    send(c1);
    drain(2, 3, 1'b0);
    chk("post_bp_valid", 32'(out_valid), 0);
    send(c1);
    drain(-1, 0, 1'b1);
    chk("b2b_valid", 32'(out_valid), 1);
    chk("b2b_data", 32'(out_data), 10);
    chk("b2b_sel", 32'(out_sel), 0);
    cur = c2;
    drain(-1, 0, 1'b0);
    chk("post_b2b_valid", 32'(out_valid), 0);
    send(c1);
    out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_rst_data", 32'(out_data), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_no_beat", 32'(out_valid), 0);
    end
    cur = c3;
    send(c3);
    drain(-1, 0, 1'b0);
    chk("post_range_valid", 32'(out_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ct_stream_out.md
Name: ct_stream_out

Overview:
- Downstream neighbour of the combinational ct-pt adder: captures one full ciphertext (CT_t, A and B vectors of N words) per valid/ready handshake.
- Serialises it as a coefficient stream, A[0..N-1] then B[0..N-1], toward memory or the host link.
- Decouples the wide combinational datapath from narrow, back-pressured consumers.

Parameters:
- N, N_SLOTS_L, coefficients per polynomial
- W, W_BITS_L, coefficient width in bits
- QP, Q_MOD_L, ciphertext modulus; used only by the optional range check
- IW, $clog2(N), index width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_ct is valid
- in_ready  output  1  block can capture in_ct
- in_ct  input  CT_t (2*N*W)  ciphertext to serialise
- out_valid  output  1  beat valid
- out_ready  input  1  consumer accepts the beat
- out_data  output  W  coefficient word
- out_sel  output  1  0 = A polynomial, 1 = B polynomial
- out_idx  output  IW  coefficient index within the polynomial
- out_last  output  1  final beat of the ciphertext (B[N-1])
- busy  output  1  a ciphertext is held or streaming
- out_range_err  output  1  current beat coefficient >= Q (optional feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE; buffer and counters = 0.
  - out_valid, out_data, out_sel, out_idx, out_last, busy, out_range_err = 0.
- FSM states: IDLE, SEND_A, SEND_B.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture in_ct into an internal buffer, cnt = 0, go to SEND_A.
  - First beat is presented registered on the next cycle (latency 1).
- SEND_A:
  - out_valid = 1, out_sel = 0, out_idx = cnt, out_data = buf.A[cnt].
  - On out_valid & out_ready: if cnt = N-1, go to SEND_B with cnt = 0; else cnt++.
- SEND_B:
  - Same beat outputs with out_sel = 1 and buf.B.
  - out_last = (cnt = N-1).
  - Handshake on the last beat returns to IDLE.
- Back-to-back: in_ready is also 1 during a handshake on an out_last beat.
  - If in_valid is high in that cycle, the new ct is captured and the FSM goes directly to SEND_A, cnt = 0.
  - Sustained throughput is 2N beats per ciphertext with no bubble.
- Backpressure: while out_valid & !out_ready, out_data, out_sel, out_idx and out_last hold stable.
  - out_valid never deasserts without a handshake.
- in_ready = 0 in SEND_A/SEND_B except on the out_last handshake cycle. in_ct is ignored whenever in_ready = 0.
- busy = (state != IDLE).
- No arithmetic on data: words pass bit-exact; no modular reduction.
- N = 1 is legal: one A beat, then one B beat with out_last = 1.
- Reset mid-stream: the buffered ct is discarded, outputs go to reset values immediately, and there is no partial replay after release.

Optional Feature:
- Macro CT_STREAM_RANGE_CHECK_EN.
- Defined: out_range_err = (out_data >= QP), computed combinationally from the registered beat and valid only while out_valid. Additionally, a sticky internal flag is set on any erroneous beat and cleared when the next ct is captured; it is exposed through out_range_err on the out_last beat as an OR of all beats.
- Undefined: the out_range_err port still exists and is tied to 0; no comparator is synthesised.

Decomposition:
- Shared types header (existing): CT_t, PT_t, word_t, N_SLOTS_L, W_BITS_L, Q_MOD_L, unchanged.
- Add the stream_state_e enum (IDLE/SEND_A/SEND_B) to the same header.
- One natural sub-module, ct_coeff_mux: combinational select of buf.A/buf.B by (sel, idx) → W-bit word, reusable by a future deserialiser's checker.

Test Plan:
- Bench setup: N=4, W=8, Q=97.
- Basic: A={1,2,3,4}, B={5,6,7,8}, out_ready=1 → 8 beats, data 1..8, sel 0,0,0,0,1,1,1,1, idx 0..3 twice, out_last only on data 8; first out_valid 1 cycle after the in handshake.
- Backpressure: out_ready low 3 cycles on beat idx=2 of A → out_data=3 held stable for all 3 cycles; no beat lost or duplicated; total beats = 8.
- Back-to-back: second ct (A={10..13}, B={20..23}) presented with in_valid at the out_last handshake → captured that cycle, next beat data=10 with no idle cycle; in_ready=0 during all other streaming cycles.
- Reset mid-stream: assert rst_n=0 at beat 5 → out_valid, busy and out_data go to 0 asynchronously; after release in_ready=1 and no beats are emitted until a new in handshake.
- Range check (macro on): B[1]=97, B[3]=200 → out_range_err=1 on those beats and on out_last; all other beats 0.
- Range check (macro off): same stimulus → out_range_err stays 0.
